// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller: decodes SCL edges and START/STOP events into
// strobes for external shift registers and selects what the slave drives on SDA.
module i2c_slave_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic [7:0] rx_data,
    input  logic       sda_in,
    output logic       rx_shift_en,
    output logic       rx_store,
    output logic       tx_load,
    output logic       tx_shift_en,
    output logic [1:0] sda_mode,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_RX,
        ADDR_CHK,
        ACK_ADDR,
        DATA_RX,
        ACK_DATA,
        LOAD_TX,
        DATA_TX,
        CHECK_ACK,
        WAIT_STOP
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_bit_cnt;
    logic [3:0] w_next_bit_cnt;
    logic       r_rw;
    logic       w_next_rw;
    logic       r_ack_ok;
    logic       w_next_ack_ok;
    logic [1:0] r_sda_mode;
    logic [1:0] w_next_sda_mode;
    logic       r_busy;
    logic       w_next_busy;
    logic       w_rise;
    logic       w_fall;
    logic       w_rx_shift_en;
    logic       w_rx_store;
    logic       w_tx_load;
    logic       w_tx_shift_en;

    // Both edge pulses in one cycle cannot be a real SCL transition.
    assign w_rise = rising_edge_found & ~falling_edge_found;
    assign w_fall = falling_edge_found & ~rising_edge_found;

    always_comb begin
        w_next_state   = r_state;
        w_next_bit_cnt = r_bit_cnt;
        w_next_rw      = r_rw;
        w_next_ack_ok  = 1'b0;
        w_rx_shift_en  = 1'b0;
        w_rx_store     = 1'b0;
        w_tx_load      = 1'b0;
        w_tx_shift_en  = 1'b0;

        if (stop_found) begin
            w_next_state   = IDLE;
            w_next_bit_cnt = 4'd0;
        end else if (start_found) begin
            w_next_state   = ADDR_RX;
            w_next_bit_cnt = 4'd0;
        end else begin
            case (r_state)
                ADDR_RX: begin
                    if (w_rise && (r_bit_cnt < 4'd8)) begin
                        w_rx_shift_en  = 1'b1;
                        w_next_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_fall && (r_bit_cnt == 4'd8)) begin
                        w_next_state = ADDR_CHK;
                    end
                end
                ADDR_CHK: begin
                    if (rx_data[7:1] == SLAVE_ADDR) begin
                        w_next_state = ACK_ADDR;
                        w_next_rw    = rx_data[0];
                    end else begin
                        w_next_state = WAIT_STOP;
                    end
                end
                ACK_ADDR: begin
                    if (w_fall) begin
                        w_next_bit_cnt = 4'd0;
                        w_next_state   = r_rw ? LOAD_TX : DATA_RX;
                    end
                end
                DATA_RX: begin
                    if (w_rise && (r_bit_cnt < 4'd8)) begin
                        w_rx_shift_en  = 1'b1;
                        w_next_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_fall && (r_bit_cnt == 4'd8)) begin
                        w_rx_store   = 1'b1;
                        w_next_state = ACK_DATA;
                    end
                end
                ACK_DATA: begin
                    if (w_fall) begin
                        w_next_bit_cnt = 4'd0;
                        w_next_state   = DATA_RX;
                    end
                end
                LOAD_TX: begin
                    // The load itself presents bit 7, so counting starts at one.
                    w_tx_load      = 1'b1;
                    w_next_bit_cnt = 4'd1;
                    w_next_state   = DATA_TX;
                end
                DATA_TX: begin
                    if (w_fall) begin
                        if (r_bit_cnt < 4'd8) begin
                            w_tx_shift_en  = 1'b1;
                            w_next_bit_cnt = r_bit_cnt + 4'd1;
                        end else begin
                            w_next_state = CHECK_ACK;
                        end
                    end
                end
                CHECK_ACK: begin
                    w_next_ack_ok = r_ack_ok;
                    if (w_rise) begin
                        if (sda_in) begin
                            w_next_state = WAIT_STOP;
                        end else begin
                            w_next_ack_ok = 1'b1;
                        end
                    end else if (w_fall && r_ack_ok) begin
                        w_next_state = LOAD_TX;
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end

        // Strobes must stay quiet in any cycle where reset is being applied.
        if (!n_rst) begin
            w_rx_shift_en = 1'b0;
            w_rx_store    = 1'b0;
            w_tx_load     = 1'b0;
            w_tx_shift_en = 1'b0;
        end
    end

    always_comb begin
        w_next_sda_mode = 2'b00;
        w_next_busy     = 1'b1;
        case (w_next_state)
            ACK_ADDR, ACK_DATA: w_next_sda_mode = 2'b01;
            DATA_TX:            w_next_sda_mode = 2'b10;
            default:            w_next_sda_mode = 2'b00;
        endcase
        if ((w_next_state == IDLE) || (w_next_state == WAIT_STOP)) begin
            w_next_busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 4'd0;
            r_rw       <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_sda_mode <= 2'b00;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_bit_cnt  <= w_next_bit_cnt;
            r_rw       <= w_next_rw;
            r_ack_ok   <= w_next_ack_ok;
            r_sda_mode <= w_next_sda_mode;
            r_busy     <= w_next_busy;
        end
    end

    assign rx_shift_en = w_rx_shift_en;
    assign rx_store    = w_rx_store;
    assign tx_load     = w_tx_load;
    assign tx_shift_en = w_tx_shift_en;
    assign sda_mode    = r_sda_mode;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Randomized bench for i2c_slave_ctrl: drives bus-level transactions and checks
// strobe counts, stored bytes and SDA mode against per-transaction expectations.
module tb_i2c_slave_ctrl;

    localparam logic [6:0] OWN_ADDR = 7'b1111000;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rise = 1'b0;
    logic       fall = 1'b0;
    logic       startF = 1'b0;
    logic       stopF = 1'b0;
    logic       sdaIn = 1'b1;
    logic [7:0] rxReg = 8'h00;
    logic       rxShiftEn;
    logic       rxStore;
    logic       txLoad;
    logic       txShiftEn;
    logic [1:0] sdaMode;
    logic       busy;

    int nChecks = 0;
    int nPass = 0;
    int cntShift = 0;
    int cntStore = 0;
    int cntLoad = 0;
    int cntTxShift = 0;
    int cntResetStrobes = 0;
    logic [7:0] storedQ[$];

    always #5 clk = ~clk;

    i2c_slave_ctrl #(.SLAVE_ADDR(OWN_ADDR)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .rising_edge_found (rise),
        .falling_edge_found(fall),
        .start_found       (startF),
        .stop_found        (stopF),
        .rx_data           (rxReg),
        .sda_in            (sdaIn),
        .rx_shift_en       (rxShiftEn),
        .rx_store          (rxStore),
        .tx_load           (txLoad),
        .tx_shift_en       (txShiftEn),
        .sda_mode          (sdaMode),
        .busy              (busy)
    );

    // Inputs change just after posedge, so mid-cycle is where the DUT's strobes
    // for the coming edge are stable; this also plays the external RX shifter.
    always @(negedge clk) begin
        if (!n_rst) begin
            if (rxShiftEn || rxStore || txLoad || txShiftEn) cntResetStrobes++;
        end else begin
            if (rxStore) storedQ.push_back(rxReg);
            if (rxShiftEn) begin
                cntShift++;
                rxReg = {rxReg[6:0], sdaIn};
            end
            if (txLoad) cntLoad++;
            if (txShiftEn) cntTxShift++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic st, input logic sp, input logic sda);
        @(posedge clk);
        #1;
        rise = r;
        fall = f;
        startF = st;
        stopF = sp;
        sdaIn = sda;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, sdaIn);
    endtask

    // One SCL period; occasionally inserts a both-edges glitch that must be ignored.
    task automatic clockBit(input logic b);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, b);
        if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, b);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, b);
        idle($urandom_range(1, 2));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, b);
        idle($urandom_range(1, 2));
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) clockBit(v[i]);
    endtask

    task automatic checkAt(input string tag, input logic [1:0] expMode, input logic expBusy);
        idle(2);
        @(negedge clk);
        checkOutput({tag, ".sda_mode"}, 32'(sdaMode), 32'(expMode));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
    endtask

    task automatic runRandomTransaction();
        logic [6:0] addr;
        logic       rw;
        logic       addressed;
        int         n;
        int         s0, st0, l0, t0;
        int         expStores, expLoads;
        logic [7:0] data[$];

        addr = ($urandom_range(0, 1) == 1) ? OWN_ADDR : 7'($urandom);
        rw = 1'($urandom_range(0, 1));
        n = $urandom_range(1, 3);
        addressed = (addr == OWN_ADDR);
        data.delete();
        for (int i = 0; i < n; i++) data.push_back(8'($urandom));
        storedQ.delete();
        s0 = cntShift;
        st0 = cntStore;
        l0 = cntLoad;
        t0 = cntTxShift;

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkAt("rnd.afterStart", 2'b00, 1'b1);
        sendByte({addr, rw});
        checkAt("rnd.addrAck", addressed ? 2'b01 : 2'b00, addressed);
        checkOutput("rnd.addrShifts", 32'(cntShift - s0), 32'd8);
        clockBit(1'b1);

        if (!addressed) begin
            sendByte(data[0]);
            clockBit(1'b0);
            checkAt("rnd.ignored", 2'b00, 1'b0);
        end else if (!rw) begin
            for (int i = 0; i < n; i++) begin
                checkAt("rnd.dataRx", 2'b00, 1'b1);
                sendByte(data[i]);
                checkAt("rnd.dataAck", 2'b01, 1'b1);
                clockBit(1'b1);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                checkAt("rnd.txMode", 2'b10, 1'b1);
                sendByte(8'($urandom));
                checkAt("rnd.checkAck", 2'b00, 1'b1);
                clockBit((i == n - 1) ? 1'b1 : 1'b0);
            end
            checkAt("rnd.nackWait", 2'b00, 1'b0);
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkAt("rnd.stopIdle", 2'b00, 1'b0);

        expStores = (addressed && !rw) ? n : 0;
        expLoads = (addressed && rw) ? n : 0;
        checkOutput("rnd.shifts", 32'(cntShift - s0), 32'(8 + 8 * expStores));
        checkOutput("rnd.stores", 32'(storedQ.size()), 32'(expStores));
        checkOutput("rnd.txLoads", 32'(cntLoad - l0), 32'(expLoads));
        checkOutput("rnd.txShifts", 32'(cntTxShift - t0), 32'(7 * expLoads));
        if (expStores > 0) begin
            for (int i = 0; i < n && i < storedQ.size(); i++) begin
                checkOutput($sformatf("rnd.byte%0d", i), 32'(storedQ[i]), 32'(data[i]));
            end
        end
        if (st0 < 0) cntStore = 0;
    endtask

    initial begin
        int s0;
        int l0;

        // Reset wins over a simultaneous START.
        n_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("reset.sda_mode", 32'(sdaMode), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle(2);
        @(negedge clk);
        checkOutput("reset.stillIdle", 32'(busy), 32'd0);

        // Repeated START after four data bits restarts address reception.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        sendByte({OWN_ADDR, 1'b0});
        clockBit(1'b1);
        s0 = cntStore;
        for (int i = 0; i < 4; i++) clockBit(1'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        sendByte({OWN_ADDR, 1'b0});
        checkAt("rstart.addrAck", 2'b01, 1'b1);
        checkOutput("rstart.noStore", 32'(cntStore - s0), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);

        // START and STOP together inside DATA_RX lands in IDLE.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        sendByte({OWN_ADDR, 1'b0});
        clockBit(1'b1);
        for (int i = 0; i < 3; i++) clockBit(1'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkAt("startStop.idle", 2'b00, 1'b0);
        s0 = cntShift;
        sendByte(8'($urandom));
        checkOutput("startStop.ignoresScl", 32'(cntShift - s0), 32'd0);

        // Reset during the fifth transmitted bit aborts the read.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        sendByte({OWN_ADDR, 1'b1});
        clockBit(1'b1);
        for (int i = 0; i < 4; i++) clockBit(1'b1);
        s0 = cntResetStrobes;
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        rise = 1'b0;
        fall = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        fall = 1'b0;
        @(negedge clk);
        checkOutput("midReset.sda_mode", 32'(sdaMode), 32'd0);
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        checkOutput("midReset.noStrobes", 32'(cntResetStrobes - s0), 32'd0);
        l0 = cntLoad;
        for (int i = 0; i < 3; i++) clockBit(1'b1);
        clockBit(1'b0);
        idle(3);
        checkOutput("midReset.noLoad", 32'(cntLoad - l0), 32'd0);

        for (int t = 0; t < 24; t++) runRandomTransaction();

        checkOutput("resetStrobesTotal", 32'(cntResetStrobes), 32'd0);
        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
